// File: rtl/elevator_scan_controller.sv
// rtl/elevator_scan_controller.sv - SCAN-ordered elevator car controller with passenger request slots
//
// Purpose: stores passenger requests in a small slot table and moves the car in
// SCAN order. The car keeps its direction while targets remain ahead and
// reverses only when nothing is ahead.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_src/      request handshake; consumed when req_ready=1
//   req_dest/req_ready
//   req_err                 one-cycle pulse after an invalid request is consumed
//   cur_floor, dir_up       car position and direction register
//   moving, door_open       car is travelling / door is open (mutually exclusive)
//   deliver, deliver_cnt    alight pulse and running count of alighted passengers
//   free_slots              number of FREE slots
module elevator_scan_controller #(
  parameter int FLOORS      = 8,
  parameter int FLOOR_W     = 3,
  parameter int SLOTS       = 4,
  parameter int MOVE_CYCLES = 10,
  parameter int DOOR_CYCLES = 25
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic [FLOOR_W-1:0] req_src,
  input  logic [FLOOR_W-1:0] req_dest,
  output logic               req_ready,
  output logic               req_err,
  output logic [FLOOR_W-1:0] cur_floor,
  output logic               moving,
  output logic               dir_up,
  output logic               door_open,
  output logic               deliver,
  output logic [15:0]        deliver_cnt,
  output logic [4:0]         free_slots
);

  localparam int MW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [MW-1:0]      MOVE_LAST = MW'(MOVE_CYCLES - 1);
  localparam logic [DW-1:0]      DOOR_LAST = DW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);

  typedef enum logic [1:0] {CAR_IDLE, CAR_MOVE, CAR_DOOR} car_state_e;
  typedef enum logic [1:0] {SLOT_FREE, SLOT_WAIT, SLOT_RIDE} slot_state_e;

  car_state_e         state_q, state_d;
  slot_state_e        slot_st_q  [SLOTS];
  slot_state_e        slot_st_d  [SLOTS];
  logic [FLOOR_W-1:0] slot_src_q [SLOTS];
  logic [FLOOR_W-1:0] slot_src_d [SLOTS];
  logic [FLOOR_W-1:0] slot_dst_q [SLOTS];
  logic [FLOOR_W-1:0] slot_dst_d [SLOTS];
  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic               dir_q, dir_d;
  logic [MW-1:0]      move_cnt_q, move_cnt_d;
  logic [DW-1:0]      door_cnt_q, door_cnt_d;
  logic               err_q, err_d;
  logic               deliver_q, deliver_d;
  logic [15:0]        deliver_cnt_q, deliver_cnt_d;

  logic [FLOOR_W-1:0] step_floor;
  logic               at_bound;
  logic [FLOOR_W-1:0] t_floor, tp_floor;
  logic               tgt_any, tgt_above, tgt_below, stop_here, step_stop;
  logic               post_above, post_below;
  logic               door_entry, late_board;
  logic [FLOOR_W-1:0] entry_floor;
  logic [4:0]         free_n, alight_n;
  logic               req_bad, accept, placed;

  always_comb begin
    step_floor = dir_q ? floor_q + 1'b1 : floor_q - 1'b1;
    at_bound   = dir_q ? (floor_q == TOP_FLOOR) : (floor_q == '0);
  end

  // Target set from registered slots. The "post" view is the set as it will be
  // once late arrivals at the current floor have boarded, which is what the
  // door-exit direction decision must look at.
  always_comb begin
    t_floor    = '0;
    tp_floor   = '0;
    tgt_any    = 1'b0;
    tgt_above  = 1'b0;
    tgt_below  = 1'b0;
    stop_here  = 1'b0;
    step_stop  = 1'b0;
    post_above = 1'b0;
    post_below = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (slot_st_q[i] != SLOT_FREE) begin
        t_floor  = (slot_st_q[i] == SLOT_WAIT) ? slot_src_q[i] : slot_dst_q[i];
        tp_floor = (slot_st_q[i] == SLOT_WAIT && slot_src_q[i] == floor_q) ? slot_dst_q[i] : t_floor;
        tgt_any    = 1'b1;
        stop_here  = stop_here  | (t_floor == floor_q);
        step_stop  = step_stop  | (t_floor == step_floor);
        tgt_above  = tgt_above  | (t_floor > floor_q);
        tgt_below  = tgt_below  | (t_floor < floor_q);
        post_above = post_above | (tp_floor > floor_q);
        post_below = post_below | (tp_floor < floor_q);
      end
    end
  end

  // Car FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= CAR_IDLE;
    else        state_q <= state_d;
  end

  // Car FSM: next state plus floor/direction/counter updates
  always_comb begin
    state_d     = state_q;
    floor_d     = floor_q;
    dir_d       = dir_q;
    move_cnt_d  = move_cnt_q;
    door_cnt_d  = door_cnt_q;
    door_entry  = 1'b0;
    late_board  = 1'b0;
    entry_floor = floor_q;
    unique case (state_q)
      CAR_IDLE: begin
        if (stop_here) begin
          state_d    = CAR_DOOR;
          door_cnt_d = '0;
          door_entry = 1'b1;
        end else if (tgt_any) begin
          // With targets on both sides the current direction is kept.
          if (tgt_above && !tgt_below)      dir_d = 1'b1;
          else if (tgt_below && !tgt_above) dir_d = 1'b0;
          state_d    = CAR_MOVE;
          move_cnt_d = '0;
        end
      end
      CAR_MOVE: begin
        if (move_cnt_q != MOVE_LAST) begin
          move_cnt_d = move_cnt_q + 1'b1;
        end else if (at_bound) begin
          state_d    = CAR_IDLE;
          move_cnt_d = '0;
        end else begin
          floor_d    = step_floor;
          move_cnt_d = '0;
          if (step_stop) begin
            state_d     = CAR_DOOR;
            door_cnt_d  = '0;
            door_entry  = 1'b1;
            entry_floor = step_floor;
          end
        end
      end
      CAR_DOOR: begin
        if (door_cnt_q != DOOR_LAST) begin
          door_cnt_d = door_cnt_q + 1'b1;
        end else begin
          late_board = 1'b1;
          door_cnt_d = '0;
          if (!post_above && !post_below) begin
            state_d = CAR_IDLE;
          end else begin
            if (dir_q ? !post_above : !post_below) dir_d = !dir_q;
            state_d    = CAR_MOVE;
            move_cnt_d = '0;
          end
        end
      end
      default: state_d = CAR_IDLE;
    endcase
  end

  // Slot table: alight/board at a stop, then accept into the lowest slot that
  // is FREE in the registered state, so a slot freed this edge is never reused
  // until the next cycle.
  always_comb begin
    req_bad = (req_src == req_dest) || (32'(req_src) >= FLOORS) || (32'(req_dest) >= FLOORS);
    accept  = req_valid && req_ready;
    slot_st_d  = slot_st_q;
    slot_src_d = slot_src_q;
    slot_dst_d = slot_dst_q;
    alight_n   = '0;
    placed     = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (door_entry && slot_st_q[i] == SLOT_RIDE && slot_dst_q[i] == entry_floor) begin
        slot_st_d[i] = SLOT_FREE;
        alight_n     = alight_n + 1'b1;
      end else if (door_entry && slot_st_q[i] == SLOT_WAIT && slot_src_q[i] == entry_floor) begin
        slot_st_d[i] = SLOT_RIDE;
      end else if (late_board && slot_st_q[i] == SLOT_WAIT && slot_src_q[i] == floor_q) begin
        slot_st_d[i] = SLOT_RIDE;
      end
    end
    for (int i = 0; i < SLOTS; i++) begin
      if (accept && !req_bad && !placed && slot_st_q[i] == SLOT_FREE) begin
        slot_st_d[i]  = SLOT_WAIT;
        slot_src_d[i] = req_src;
        slot_dst_d[i] = req_dest;
        placed        = 1'b1;
      end
    end
    err_d         = accept && req_bad;
    deliver_d     = door_entry && (alight_n != '0);
    deliver_cnt_d = deliver_cnt_q + 16'(alight_n);
  end

  always_comb begin
    free_n = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (slot_st_q[i] == SLOT_FREE) free_n = free_n + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) begin
        slot_st_q[i]  <= SLOT_FREE;
        slot_src_q[i] <= '0;
        slot_dst_q[i] <= '0;
      end
      floor_q       <= '0;
      dir_q         <= 1'b1;
      move_cnt_q    <= '0;
      door_cnt_q    <= '0;
      err_q         <= 1'b0;
      deliver_q     <= 1'b0;
      deliver_cnt_q <= '0;
    end else begin
      slot_st_q     <= slot_st_d;
      slot_src_q    <= slot_src_d;
      slot_dst_q    <= slot_dst_d;
      floor_q       <= floor_d;
      dir_q         <= dir_d;
      move_cnt_q    <= move_cnt_d;
      door_cnt_q    <= door_cnt_d;
      err_q         <= err_d;
      deliver_q     <= deliver_d;
      deliver_cnt_q <= deliver_cnt_d;
    end
  end

  // Car FSM: outputs
  always_comb begin
    moving      = (state_q == CAR_MOVE);
    door_open   = (state_q == CAR_DOOR);
    cur_floor   = floor_q;
    dir_up      = dir_q;
    req_ready   = (free_n != '0);
    free_slots  = free_n;
    req_err     = err_q;
    deliver     = deliver_q;
    deliver_cnt = deliver_cnt_q;
  end

endmodule

// File: tb/tb_elevator_scan_controller.sv
// tb/tb_elevator_scan_controller.sv - self-checking bench for elevator_scan_controller
module tb_elevator_scan_controller;
  localparam int FLOORS = 8, FLOOR_W = 4, SLOTS = 4, MOVE_CYCLES = 2, DOOR_CYCLES = 3;
  localparam int ST_FREE = 0, ST_WAIT = 1, ST_RIDE = 2;
  localparam int PH_IDLE = 0, PH_MOVE = 1, PH_DOOR = 2;
  localparam logic [30:0] RESET_VEC = {1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 5'd4};

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               req_valid = 1'b0;
  logic [FLOOR_W-1:0] req_src = '0;
  logic [FLOOR_W-1:0] req_dest = '0;
  logic               req_ready, req_err, moving, dir_up, door_open, deliver;
  logic [FLOOR_W-1:0] cur_floor;
  logic [15:0]        deliver_cnt;
  logic [4:0]         free_slots;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  elevator_scan_controller #(
    .FLOORS(FLOORS), .FLOOR_W(FLOOR_W), .SLOTS(SLOTS),
    .MOVE_CYCLES(MOVE_CYCLES), .DOOR_CYCLES(DOOR_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_src(req_src), .req_dest(req_dest),
    .req_ready(req_ready), .req_err(req_err), .cur_floor(cur_floor), .moving(moving),
    .dir_up(dir_up), .door_open(door_open), .deliver(deliver), .deliver_cnt(deliver_cnt),
    .free_slots(free_slots)
  );

  // Reference model: floors as integers, timers counting down remaining cycles.
  int m_phase, m_left, m_floor, m_cnt;
  bit m_up, m_err, m_del;
  int m_st [SLOTS];
  int m_src[SLOTS];
  int m_dst[SLOTS];

  int stops[$];
  bit stop_dirs[$];
  bit prev_door = 1'b0;

  task automatic m_reset();
    m_phase = PH_IDLE; m_left = 0; m_floor = 0; m_cnt = 0;
    m_up = 1'b1; m_err = 1'b0; m_del = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      m_st[i] = ST_FREE; m_src[i] = 0; m_dst[i] = 0;
    end
  endtask

  function automatic int m_free_cnt();
    int n = 0;
    for (int i = 0; i < SLOTS; i++) if (m_st[i] == ST_FREE) n++;
    return n;
  endfunction

  function automatic bit m_is_target(int f);
    for (int i = 0; i < SLOTS; i++)
      if ((m_st[i] == ST_WAIT && m_src[i] == f) || (m_st[i] == ST_RIDE && m_dst[i] == f)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_any_in(int lo, int hi);
    for (int f = lo; f <= hi; f++) if (m_is_target(f)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_arrive(int f);
    int n = 0;
    m_phase = PH_DOOR;
    m_left  = DOOR_CYCLES;
    for (int i = 0; i < SLOTS; i++) begin
      if (m_st[i] == ST_RIDE && m_dst[i] == f) begin
        m_st[i] = ST_FREE; n++;
      end else if (m_st[i] == ST_WAIT && m_src[i] == f) begin
        m_st[i] = ST_RIDE;
      end
    end
    m_del = (n > 0);
    m_cnt = (m_cnt + n) % 65536;
  endtask

  task automatic m_step(bit v, int s, int d);
    bit was_free[SLOTS];
    bit ready, above, below, done;
    int nf;
    for (int i = 0; i < SLOTS; i++) was_free[i] = (m_st[i] == ST_FREE);
    ready = (m_free_cnt() > 0);
    m_err = 1'b0;
    m_del = 1'b0;
    case (m_phase)
      PH_IDLE: begin
        above = m_any_in(m_floor + 1, FLOORS - 1);
        below = m_any_in(0, m_floor - 1);
        if (m_is_target(m_floor)) m_arrive(m_floor);
        else if (above || below) begin
          if (above && !below) m_up = 1'b1;
          else if (below && !above) m_up = 1'b0;
          m_phase = PH_MOVE; m_left = MOVE_CYCLES;
        end
      end
      PH_MOVE: begin
        if (m_left > 1) m_left--;
        else begin
          nf = m_up ? m_floor + 1 : m_floor - 1;
          if (nf < 0 || nf >= FLOORS) m_phase = PH_IDLE;
          else begin
            m_floor = nf;
            if (m_is_target(nf)) m_arrive(nf);
            else m_left = MOVE_CYCLES;
          end
        end
      end
      default: begin
        if (m_left > 1) m_left--;
        else begin
          for (int i = 0; i < SLOTS; i++)
            if (m_st[i] == ST_WAIT && m_src[i] == m_floor) m_st[i] = ST_RIDE;
          above = m_any_in(m_floor + 1, FLOORS - 1);
          below = m_any_in(0, m_floor - 1);
          if (!above && !below) m_phase = PH_IDLE;
          else begin
            if (m_up ? !above : !below) m_up = !m_up;
            m_phase = PH_MOVE; m_left = MOVE_CYCLES;
          end
        end
      end
    endcase
    if (v && ready) begin
      if (s == d || s >= FLOORS || d >= FLOORS) m_err = 1'b1;
      else begin
        done = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
          if (was_free[i] && !done) begin
            m_st[i] = ST_WAIT; m_src[i] = s; m_dst[i] = d; done = 1'b1;
          end
        end
      end
    end
  endtask

  function automatic logic [30:0] dut_vec();
    return {req_ready, req_err, cur_floor, moving, dir_up, door_open, deliver, deliver_cnt, free_slots};
  endfunction

  function automatic logic [30:0] mdl_vec();
    return {m_free_cnt() > 0, m_err, 4'(m_floor), m_phase == PH_MOVE, m_up, m_phase == PH_DOOR,
            m_del, 16'(m_cnt), 5'(m_free_cnt())};
  endfunction

  task automatic check(string name, int act, int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cycle(bit v, int s, int d);
    req_valid = v;
    req_src   = 4'(s);
    req_dest  = 4'(d);
    @(posedge clk);
    if (!rst_n) m_reset();
    else m_step(v, int'(req_src), int'(req_dest));
    #1;
    check("model", int'(dut_vec()), int'(mdl_vec()));
    if (door_open && !prev_door) begin
      stops.push_back(int'(cur_floor));
      stop_dirs.push_back(dir_up);
    end
    prev_door = door_open;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    prev_door = 1'b0;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit v; int s; int d;
    bit rdy; bit err; int flr; bit mov; bit dir; bit door; bit del; int cnt; int free;
  } vec_t;

  function automatic vec_t mk(bit v, int s, int d, bit rdy, bit err, int flr, bit mov, bit dir,
                              bit door, bit del, int cnt, int free);
    vec_t t;
    t.v = v; t.s = s; t.d = d; t.rdy = rdy; t.err = err; t.flr = flr; t.mov = mov;
    t.dir = dir; t.door = door; t.del = del; t.cnt = cnt; t.free = free;
    return t;
  endfunction

  function automatic int pack_exp(vec_t t);
    logic [30:0] p;
    p = {t.rdy, t.err, 4'(t.flr), t.mov, t.dir, t.door, t.del, 16'(t.cnt), 5'(t.free)};
    return int'(p);
  endfunction

  vec_t tbl[20];

  initial begin
    int n;
    bit flag;
    int exp_stops[6];

    // Invalid requests, then the basic 0 -> 3 trip, one record per clock.
    tbl[0]  = mk(1, 2, 2, 1, 1, 0, 0, 1, 0, 0, 0, 4);
    tbl[1]  = mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 4);
    tbl[2]  = mk(1, 9, 1, 1, 1, 0, 0, 1, 0, 0, 0, 4);
    tbl[3]  = mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 4);
    tbl[4]  = mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 4);
    tbl[5]  = mk(1, 0, 3, 1, 0, 0, 0, 1, 0, 0, 0, 3);
    tbl[6]  = mk(0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 3);
    tbl[7]  = mk(0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 3);
    tbl[8]  = mk(0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 3);
    tbl[9]  = mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 3);
    tbl[10] = mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 3);
    tbl[11] = mk(0, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0, 3);
    tbl[12] = mk(0, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0, 3);
    tbl[13] = mk(0, 0, 0, 1, 0, 2, 1, 1, 0, 0, 0, 3);
    tbl[14] = mk(0, 0, 0, 1, 0, 2, 1, 1, 0, 0, 0, 3);
    tbl[15] = mk(0, 0, 0, 1, 0, 3, 0, 1, 1, 1, 1, 4);
    tbl[16] = mk(0, 0, 0, 1, 0, 3, 0, 1, 1, 0, 1, 4);
    tbl[17] = mk(0, 0, 0, 1, 0, 3, 0, 1, 1, 0, 1, 4);
    tbl[18] = mk(0, 0, 0, 1, 0, 3, 0, 1, 0, 0, 1, 4);
    tbl[19] = mk(0, 0, 0, 1, 0, 3, 0, 1, 0, 0, 1, 4);

    do_reset();
    check("reset_values", int'(dut_vec()), int'(RESET_VEC));
    for (int i = 0; i < 20; i++) begin
      cycle(tbl[i].v, tbl[i].s, tbl[i].d);
      check($sformatf("table_%0d", i), int'(dut_vec()), pack_exp(tbl[i]));
    end

    // Full table and back-pressure on a fifth request.
    do_reset();
    cycle(1, 0, 1); cycle(1, 0, 2); cycle(1, 0, 3); cycle(1, 0, 4);
    check("full_ready", int'(req_ready), 0);
    check("full_free", int'(free_slots), 0);
    n = 0; flag = 1'b0;
    while (!deliver && n < 200) begin
      if (req_ready) flag = 1'b1;
      cycle(1, 5, 6);
      n++;
    end
    check("bp_deliver_seen", int'(deliver), 1);
    check("bp_ready_before_deliver", int'(flag), 0);
    check("bp_ready_at_deliver", int'(req_ready), 1);
    check("bp_free_at_deliver", int'(free_slots), 1);
    cycle(1, 5, 6);
    check("bp_accepted", int'(free_slots), 0);
    cycle(0, 0, 0);
    check("bp_single_accept", int'(free_slots), 0);

    // SCAN ordering with requests joining mid-trip.
    do_reset();
    stops.delete(); stop_dirs.delete();
    cycle(1, 0, 6);
    n = 0;
    while (cur_floor != 4'd1 && n < 100) begin cycle(0, 0, 0); n++; end
    check("scan_reach_1", int'(cur_floor), 1);
    cycle(1, 4, 5);
    n = 0;
    while (cur_floor != 4'd3 && n < 100) begin cycle(0, 0, 0); n++; end
    check("scan_reach_3", int'(cur_floor), 3);
    cycle(1, 1, 0);
    repeat (120) cycle(0, 0, 0);
    exp_stops = '{0, 4, 5, 6, 1, 0};
    check("scan_stop_count", stops.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("scan_stop_%0d", i), (i < stops.size()) ? stops[i] : -1, exp_stops[i]);
    check("scan_dir_at_1", (stop_dirs.size() > 4) ? int'(stop_dirs[4]) : -1, 0);
    check("scan_deliver_cnt", int'(deliver_cnt), 3);
    check("scan_idle", int'({moving, door_open}), 0);

    // Asynchronous reset while travelling between floors 2 and 3.
    do_reset();
    cycle(1, 0, 5); cycle(1, 1, 6);
    n = 0;
    while (!(cur_floor == 4'd2 && moving) && n < 100) begin cycle(0, 0, 0); n++; end
    check("rm_between_2_3", int'({cur_floor, moving, dir_up}), int'({4'd2, 1'b1, 1'b1}));
    check("rm_occupied", int'(free_slots), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("rm_async_values", int'(dut_vec()), int'(RESET_VEC));
    @(posedge clk);
    #1;
    check("rm_held_values", int'(dut_vec()), int'(RESET_VEC));
    m_reset();
    prev_door = 1'b0;
    rst_n = 1'b1;
    flag = 1'b0;
    repeat (30) begin
      cycle(0, 0, 0);
      if (moving || deliver || door_open) flag = 1'b1;
    end
    check("rm_no_activity", int'(flag), 0);
    check("rm_floor", int'(cur_floor), 0);

    // Randomized traffic against the model, with occasional resets.
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      else cycle($urandom_range(0, 3) == 0, int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
